// File: rtl/pwm_fade_sequencer.sv
// PWM generator with a period counter and a duty ramp sequencer that walks the
// applied duty one LSB per 2^rate periods toward a commanded target.
module pwm_fade_sequencer #(
  parameter int WIDTH  = 8,
  parameter int RATE_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_target,
  input  logic [RATE_W-1:0] cmd_rate,
  input  logic              abort,
  output logic [WIDTH-1:0]  duty,
  output logic              pwm_out,
  output logic              period_start,
  output logic              busy,
  output logic              done
);

  localparam int STEP_W = (1 << RATE_W) - 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    cnt_q;
  logic [WIDTH-1:0]    duty_q;
  logic [WIDTH-1:0]    target_q;
  logic [RATE_W-1:0]   rate_q;
  logic [STEP_W-1:0]   step_cnt_q;
  logic                busy_q;
  logic                done_q;

  logic [WIDTH-1:0]    cnt_d;
  logic [WIDTH-1:0]    duty_d;
  logic [STEP_W-1:0]   step_limit_s;
  logic                wrap_s;
  logic                step_due_s;
  logic                final_step_s;

  // Next-step arithmetic: duty_d is only used while ramping, so duty_q != target_q and it never wraps.
  always_comb begin
    cnt_d        = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    step_limit_s = STEP_W'((32'd1 << rate_q) - 32'd1);
    wrap_s       = ena & (cnt_q == {WIDTH{1'b1}});
    step_due_s   = wrap_s & (step_cnt_q == step_limit_s);
    if (target_q > duty_q) begin
      duty_d = duty_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      duty_d = duty_q - {{(WIDTH-1){1'b0}}, 1'b1};
    end
    final_step_s = step_due_s & (duty_d == target_q);
  end

  // Period counter, command latch and ramp FSM; everything freezes while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= {WIDTH{1'b0}};
      duty_q     <= {WIDTH{1'b0}};
      target_q   <= {WIDTH{1'b0}};
      rate_q     <= {RATE_W{1'b0}};
      step_cnt_q <= {STEP_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (!ena) begin
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            target_q   <= cmd_target;
            rate_q     <= cmd_rate;
            step_cnt_q <= {STEP_W{1'b0}};
            if (cmd_target == duty_q) begin
              done_q <= 1'b1;
            end else begin
              state_q <= RAMP;
              busy_q  <= 1'b1;
            end
          end
        end
        RAMP: begin
          if (abort) begin
            // A final step landing with abort still completes the duty, but without done.
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            step_cnt_q <= {STEP_W{1'b0}};
            if (final_step_s) begin
              duty_q <= duty_d;
            end
          end else if (wrap_s) begin
            if (step_due_s) begin
              duty_q     <= duty_d;
              step_cnt_q <= {STEP_W{1'b0}};
              if (final_step_s) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              step_cnt_q <= step_cnt_q + {{(STEP_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign duty         = duty_q;
  assign pwm_out      = ena & (cnt_q < duty_q);
  assign period_start = ena & (cnt_q == {WIDTH{1'b0}});
  assign cmd_ready    = ena & (state_q == IDLE);
  assign busy         = busy_q;
  assign done         = ena & done_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Scoreboard bench: each command pushes its expected completion (final duty, wrap count, latency);
// a negedge monitor pops and checks on every done pulse.
module tb_pwm_fade_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, ena, cmd_valid, cmd_ready, abort;
  logic [7:0] cmd_target;
  logic [3:0] cmd_rate;
  logic [7:0] duty;
  logic       pwm_out, period_start, busy, done;

  pwm_fade_sequencer #(.WIDTH(8), .RATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_rate(cmd_rate), .abort(abort),
    .duty(duty), .pwm_out(pwm_out), .period_start(period_start),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int duty;
    int wraps;
    int lat;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   wraps = 0;
  int   lat = 0;
  bit   tracking = 1'b0;
  bit   skip = 1'b0;
  int   ready_while_busy = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: counts wraps seen after an accept and scores every done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tracking = 1'b0;
      end else begin
        if (busy && cmd_ready) ready_while_busy++;
        if (tracking) begin
          lat++;
          if (skip) skip = 1'b0;
          else if (period_start) wraps++;
        end
        if (done) begin
          if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            check("done_duty", int'(duty), e.duty);
            check("done_wraps", wraps, e.wraps);
            if (e.lat >= 0) check("done_latency", lat, e.lat);
            check("busy_at_done", int'(busy), 0);
            if (e.wraps > 0) check("done_at_cnt0", int'(period_start), 1);
          end
          tracking = 1'b0;
        end
        if (cmd_valid && cmd_ready) begin
          tracking = 1'b1;
          skip     = 1'b1;
          wraps    = 0;
          lat      = 0;
        end
      end
    end
  end

  task automatic send(input int tgt, input int rate, input bit push, input int exp_wraps, input int exp_lat);
    int n;
    exp_t e;
    @(posedge clk); #1;
    if (push) begin
      e.duty = tgt; e.wraps = exp_wraps; e.lat = exp_lat;
      q.push_back(e);
    end
    cmd_valid  = 1'b1;
    cmd_target = 8'(tgt);
    cmd_rate   = 4'(rate);
    n = 0;
    while (!cmd_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) timeout("send");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) timeout("wait_idle");
  endtask

  task automatic wait_wraps(input int k);
    int n;
    n = 0;
    while (wraps < k && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) timeout("wait_wraps");
  endtask

  initial begin
    int pwm_hi, ps_cnt, frozen_hi, exp_duty;
    rst_n = 1'b0; ena = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    cmd_target = 8'd0; cmd_rate = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_duty", int'(duty), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_ready_ena0", int'(cmd_ready), 0);
    rst_n = 1'b1; ena = 1'b1;
    #1;
    check("idle_ready", int'(cmd_ready), 1);

    pwm_hi = 0; ps_cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      pwm_hi += int'(pwm_out);
      ps_cnt += int'(period_start);
    end
    check("idle_pwm_high", pwm_hi, 0);
    check("idle_period_starts", ps_cnt, 4);

    send(4, 0, 1'b1, 4, -1);
    wait_idle(3000);
    pwm_hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pwm_hi += int'(pwm_out);
    end
    check("duty4_pwm_high", pwm_hi, 4);

    send(2, 2, 1'b1, 8, -1);
    wait_idle(4000);

    send(2, 0, 1'b1, 0, 1);
    wait_idle(100);
    check("equal_duty", int'(duty), 2);

    send(0, 0, 1'b1, 2, -1);
    wait_idle(1000);
    send(200, 0, 1'b0, 0, 0);
    wait_wraps(10);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_duty", int'(duty), 10);
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(cmd_ready), 1);
    repeat (600) @(posedge clk);
    #1;
    check("abort_duty_hold", int'(duty), 10);
    send(12, 0, 1'b1, 2, -1);
    wait_idle(1000);

    send(20, 0, 1'b1, 8, -1);
    wait_wraps(3);
    exp_duty = 12 + wraps;
    ena = 1'b0;
    #1;
    check("freeze_duty_start", int'(duty), exp_duty);
    frozen_hi = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      frozen_hi += int'(pwm_out | period_start | cmd_ready | done);
    end
    check("freeze_outputs_low", frozen_hi, 0);
    check("freeze_duty_end", int'(duty), exp_duty);
    @(posedge clk); #1;
    ena = 1'b1;
    wait_idle(3000);

    send(50, 0, 1'b0, 0, 0);
    wait_wraps(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_duty", int'(duty), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_pwm", int'(pwm_out), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", int'(cmd_ready), 1);
    repeat (300) @(posedge clk);
    #1;

    check("ready_while_busy", ready_while_busy, 0);
    check("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
